// File: rtl/mem_port_arbiter.sv
// Shares one level-enable / ready-pulse memory port among NUM_PORTS requesters,
// round-robin or fixed priority, with per-port held read data and a ready watchdog.
module mem_port_arbiter #(
  parameter int NUM_PORTS     = 2,
  parameter int ADDR_WIDTH    = 19,
  parameter int DATA_WIDTH    = 8,
  parameter int PRIORITY_MODE = 0,
  parameter int TIMEOUT       = 1024
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_PORTS-1:0]            port_re,
  input  logic [NUM_PORTS-1:0]            port_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] port_rdata,
  output logic [NUM_PORTS-1:0]            port_rd_ready,
  output logic [NUM_PORTS-1:0]            port_wr_ready,
  output logic [NUM_PORTS-1:0]            port_err,
  output logic                            mem_re,
  output logic                            mem_we,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  input  logic                            mem_rd_ready,
  input  logic                            mem_wr_ready,
  output logic                            busy,
  output logic [$clog2(NUM_PORTS)-1:0]    grant_id
);

  localparam int GW          = $clog2(NUM_PORTS);
  localparam int SW          = GW + 1;
  localparam int CW          = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int WDOG_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] WDOG_LAST = WDOG_LAST_I[CW-1:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_last_grant;
  logic            r_op_write;
  logic [CW-1:0]   r_wdog;

  logic [NUM_PORTS-1:0] w_req;
  logic [GW-1:0]        w_winner;
  logic [SW-1:0]        w_sum;
  logic                 w_timeout;

  // NOTE: combinational logic uses blocking '=' with a default for every signal
  // first, so no latch is inferred; all state below uses non-blocking '<='.
  always_comb begin
    w_req    = port_re | port_we;
    w_winner = '0;
    w_sum    = '0;
    if (PRIORITY_MODE == 1) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (w_req[i]) w_winner = GW'(i);
      end
    end else begin
      // Scan downward so the last hit is the first requester after r_last_grant.
      for (int k = NUM_PORTS; k >= 1; k--) begin
        w_sum = {1'b0, r_last_grant} + SW'(k);
        if (w_sum >= SW'(NUM_PORTS)) w_sum = w_sum - SW'(NUM_PORTS);
        if (w_req[w_sum[GW-1:0]]) w_winner = w_sum[GW-1:0];
      end
    end
  end

  assign w_timeout = (TIMEOUT != 0) && (r_wdog == WDOG_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_last_grant  <= GW'(NUM_PORTS - 1);
      r_op_write    <= 1'b0;
      r_wdog        <= '0;
      // NOTE: port_rdata is a small register bank rather than a RAM, so it is
      // cleared by reset like every other output.
      port_rdata    <= '0;
      port_rd_ready <= '0;
      port_wr_ready <= '0;
      port_err      <= '0;
      mem_re        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      busy          <= 1'b0;
      grant_id      <= '0;
    end else begin
      port_rd_ready <= '0;
      port_wr_ready <= '0;
      port_err      <= '0;
      case (r_state)
        S_IDLE: begin
          if (|w_req) begin
            r_state      <= S_BUSY;
            r_last_grant <= w_winner;
            grant_id     <= w_winner;
            r_op_write   <= port_we[w_winner];
            mem_we       <= port_we[w_winner];
            mem_re       <= ~port_we[w_winner];
            mem_addr     <= port_addr[int'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata    <= port_wdata[int'(w_winner)*DATA_WIDTH +: DATA_WIDTH];
            r_wdog       <= '0;
            busy         <= 1'b1;
          end
        end
        S_BUSY: begin
          r_wdog <= r_wdog + CW'(1);
          if (!r_op_write && mem_rd_ready) begin
            port_rdata[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
            port_rd_ready[grant_id] <= 1'b1;
            mem_re  <= 1'b0;
            r_state <= S_DONE;
          end else if (r_op_write && mem_wr_ready) begin
            port_wr_ready[grant_id] <= 1'b1;
            mem_we  <= 1'b0;
            r_state <= S_DONE;
          end else if (w_timeout) begin
            port_err[grant_id] <= 1'b1;
            mem_re  <= 1'b0;
            mem_we  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          mem_re  <= 1'b0;
          mem_we  <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
